// File: rtl/asg_trig_sched.sv
`default_nettype none
// ============================================================================
// Module   : asg_trig_sched
// Purpose  : Trigger pulse-train scheduler for the arbitrary signal generator
//            (dac_clk domain). A train starts on a software start or on an
//            external trigger edge and runs: start delay, then N pulses of
//            programmable width at a fixed period (N = 0 repeats forever).
// Options  : ASG_TRIG_SCHED_CNT_EN - expose the completed-pulse count on cnt_o
//            (otherwise cnt_o is tied to zero).
// Revision : 1.0 - initial release
// ============================================================================
module asg_trig_sched #(
   parameter int CW = 32
) (
   input  logic          dac_clk_i,
   input  logic          dac_rstn_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          use_ext_i,
   input  logic          ext_trig_i,
   input  logic [CW-1:0] delay_i,
   input  logic [CW-1:0] per_i,
   input  logic [CW-1:0] wid_i,
   input  logic [CW-1:0] num_i,
   output logic          trig_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [CW-1:0] cnt_o
);

   localparam logic [CW-1:0] c_zero = '0;
   localparam logic [CW-1:0] c_one  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_DELAY = 3'd2,
      S_PULSE = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;          // delay count, then cycles since pulse start
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] r_pulses;       // completed pulses in the current train
   logic [CW-1:0] w_pulses_nxt;
   logic [CW-1:0] w_pulses_inc;
   logic [CW-1:0] r_delay;
   logic [CW-1:0] r_wid_m1;       // effective width - 1
   logic [CW-1:0] r_per_m1;       // effective period - 1
   logic [CW-1:0] r_num;
   logic          r_ext_q;
   logic          r_done_p;
   logic          w_done_p_nxt;
   logic          w_accept;
   logic          w_edge;
   logic          w_last;
   logic [CW-1:0] w_wid_e;
   logic [CW-1:0] w_per_m1;

   // The state register runs one cycle ahead of the registered outputs, which
   // gives the fixed one-cycle trigger latency and keeps outputs glitch-free.
   assign w_accept = (r_state == S_IDLE) && !busy_o && start_i && !stop_i;
   assign w_edge   = ext_trig_i && !r_ext_q;
   assign w_last   = (r_num != c_zero) && (r_pulses == r_num);

   // Clamp width to >= 1 and period to >= width + 1, expressed as period - 1
   // so the all-ones width case cannot overflow.
   assign w_wid_e  = (wid_i == c_zero) ? c_one : wid_i;
   assign w_per_m1 = (per_i > w_wid_e) ? (per_i - c_one) : w_wid_e;

`ifdef ASG_TRIG_SCHED_CNT_EN
   assign w_pulses_inc = (&r_pulses) ? r_pulses : (r_pulses + c_one);
`else
   // Only the num compare needs the count, so infinite trains leave it alone.
   assign w_pulses_inc = (r_num == c_zero) ? r_pulses : (r_pulses + c_one);
`endif

   // Edge detector history, tracked in every state.
   always_ff @(posedge dac_clk_i) begin
      r_ext_q <= ext_trig_i;
   end

   // State, counters and pending-done register.
   always_ff @(posedge dac_clk_i) begin
      if (!dac_rstn_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= c_zero;
         r_pulses <= c_zero;
         r_done_p <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pulses <= w_pulses_nxt;
         r_done_p <= w_done_p_nxt;
      end
   end

   // Next-state and counter logic; stop overrides everything.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_pulses_nxt = r_pulses;
      w_done_p_nxt = 1'b0;
      if (stop_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_cnt_nxt    = c_zero;
                  w_pulses_nxt = c_zero;
                  if (use_ext_i)
                     w_state_nxt = S_ARM;
                  else if (delay_i == c_zero)
                     w_state_nxt = S_PULSE;
                  else
                     w_state_nxt = S_DELAY;
               end
            end
            S_ARM: begin
               if (w_edge) begin
                  w_cnt_nxt   = c_zero;
                  w_state_nxt = (r_delay == c_zero) ? S_PULSE : S_DELAY;
               end
            end
            S_DELAY: begin
               if (r_cnt == (r_delay - c_one)) begin
                  w_cnt_nxt   = c_zero;
                  w_state_nxt = S_PULSE;
               end else begin
                  w_cnt_nxt = r_cnt + c_one;
               end
            end
            S_PULSE: begin
               w_cnt_nxt = r_cnt + c_one;
               if (r_cnt == r_wid_m1) begin
                  w_state_nxt  = S_GAP;
                  w_pulses_nxt = w_pulses_inc;
               end
            end
            S_GAP: begin
               if (r_cnt == r_per_m1) begin
                  w_cnt_nxt = c_zero;
                  if (w_last) begin
                     w_state_nxt  = S_IDLE;
                     w_done_p_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_PULSE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + c_one;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Configuration snapshot taken when a start is accepted.
   always_ff @(posedge dac_clk_i) begin
      if (!dac_rstn_i) begin
         r_delay  <= c_zero;
         r_wid_m1 <= c_zero;
         r_per_m1 <= c_one;
         r_num    <= c_zero;
      end else if (w_accept) begin
         r_delay  <= delay_i;
         r_wid_m1 <= w_wid_e - c_one;
         r_per_m1 <= w_per_m1;
         r_num    <= num_i;
      end
   end

   // Registered outputs; a stop forces them low on the following cycle.
   always_ff @(posedge dac_clk_i) begin
      if (!dac_rstn_i) begin
         trig_o <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         trig_o <= !stop_i && (r_state == S_PULSE);
         busy_o <= !stop_i && (r_state != S_IDLE);
         done_o <= !stop_i && r_done_p;
      end
   end

`ifdef ASG_TRIG_SCHED_CNT_EN
   logic [CW-1:0] r_cnt_out;

   // Visible pulse count: cleared on accepted start, otherwise follows the
   // internal count so it updates on the cycle trig_o falls.
   always_ff @(posedge dac_clk_i) begin
      if (!dac_rstn_i)
         r_cnt_out <= c_zero;
      else if (w_accept)
         r_cnt_out <= c_zero;
      else
         r_cnt_out <= r_pulses;
   end

   assign cnt_o = r_cnt_out;
`else
   assign cnt_o = c_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_asg_trig_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_asg_trig_sched
// Purpose  : Self-checking bench for asg_trig_sched. A timing model predicts
//            every output from the trigger time and the effective pulse
//            parameters; directed sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asg_trig_sched;

   localparam int CW  = 32;
   localparam int INF = 32'h3fffffff;

   logic          dac_clk  = 1'b0;
   logic          dac_rstn = 1'b0;
   logic          start    = 1'b0;
   logic          stop     = 1'b0;
   logic          use_ext  = 1'b0;
   logic          ext_trig = 1'b0;
   logic [CW-1:0] delay_v  = '0;
   logic [CW-1:0] per_v    = '0;
   logic [CW-1:0] wid_v    = '0;
   logic [CW-1:0] num_v    = '0;
   logic          trig, busy, done;
   logic [CW-1:0] cnt;

   int asserts = 0;
   int fails   = 0;
   int cyc     = 0;

   always #5 dac_clk = ~dac_clk;

   asg_trig_sched #(.CW(CW)) dut (
      .dac_clk_i  (dac_clk),
      .dac_rstn_i (dac_rstn),
      .start_i    (start),
      .stop_i     (stop),
      .use_ext_i  (use_ext),
      .ext_trig_i (ext_trig),
      .delay_i    (delay_v),
      .per_i      (per_v),
      .wid_i      (wid_v),
      .num_i      (num_v),
      .trig_o     (trig),
      .busy_o     (busy),
      .done_o     (done),
      .cnt_o      (cnt)
   );

   // ---------------- timing model ----------------
   bit m_active   = 1'b0;
   bit m_fired    = 1'b0;
   bit m_ext_prev = 1'b0;
   int m_tstart = 0, m_tfire = 0, m_stop = INF;
   int m_d = 0, m_w = 1, m_p = 2, m_n = 0;
   bit e_trig = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   int e_cnt  = 0;

   function automatic int f_first();
      return m_tfire + m_d + 1;
   endfunction

   function automatic int f_end();
      if (!m_fired || m_n == 0) return INF;
      return f_first() + m_n * m_p;
   endfunction

   // Number of pulses whose falling edge is at or before edge m.
   function automatic int f_falls(input int m);
      int c;
      if (!m_fired || (m - f_first() - m_w) < 0) return 0;
      c = (m - f_first() - m_w) / m_p + 1;
      if (m_n != 0 && c > m_n) c = m_n;
      return c;
   endfunction

   always @(posedge dac_clk) begin : model
      int  k, lim, first;
      bit  idle, acc;
      cyc = cyc + 1;
      k   = cyc;
      if (!dac_rstn) begin
         m_active = 1'b0;
      end else begin
         idle = !m_active || (k > m_stop) || (k > f_end());
         acc  = start && !stop && idle;
         if (m_active && stop && m_stop == INF) m_stop = k;
         if (acc) begin
            m_active = 1'b1;
            m_tstart = k;
            m_stop   = INF;
            m_fired  = !use_ext;
            m_tfire  = k;
            m_d      = int'(delay_v);
            m_w      = (wid_v == 0) ? 1 : int'(wid_v);
            m_p      = (int'(per_v) > m_w) ? int'(per_v) : m_w + 1;
            m_n      = int'(num_v);
         end else if (m_active && !m_fired && m_stop == INF && ext_trig && !m_ext_prev) begin
            m_fired = 1'b1;
            m_tfire = k;
         end
      end
      m_ext_prev = ext_trig;
      first  = f_first();
      lim    = (f_end() < m_stop) ? f_end() : m_stop;
      e_trig = m_active && m_fired && k >= first && k < lim && ((k - first) % m_p) < m_w;
      e_busy = m_active && k > m_tstart && k < lim;
      e_done = m_active && m_fired && m_n != 0 && k == f_end() && f_end() < m_stop;
`ifdef ASG_TRIG_SCHED_CNT_EN
      e_cnt  = m_active ? f_falls((k < m_stop) ? k : m_stop) : 0;
`else
      e_cnt  = 0;
`endif
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts = asserts + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge dac_clk) begin
      if (cyc >= 1) begin
         check("model_trig", {31'b0, trig}, {31'b0, e_trig});
         check("model_busy", {31'b0, busy}, {31'b0, e_busy});
         check("model_done", {31'b0, done}, {31'b0, e_done});
         check("model_cnt",  cnt, e_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_until(input int k);
      while (cyc < k) @(negedge dac_clk);
   endtask

   // Called at a negedge; returns the edge number that sampled start.
   task automatic do_start(input int d, input int p, input int w, input int n,
                           input bit ue, output int t);
      delay_v = d; per_v = p; wid_v = w; num_v = n; use_ext = ue; start = 1'b1;
      @(negedge dac_clk);
      start = 1'b0;
      t     = cyc;
      delay_v = $urandom_range(0, 7);
      per_v   = $urandom_range(0, 7);
      wid_v   = $urandom_range(0, 7);
      num_v   = $urandom_range(0, 7);
      use_ext = $urandom_range(0, 1);
   endtask

   initial begin : stim
      int t, e;
      repeat (3) @(negedge dac_clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_trig", {31'b0, trig}, 32'd0);
      dac_rstn = 1'b1;
      @(negedge dac_clk);

      // Basic train
      do_start(5, 10, 3, 4, 1'b0, t);
      wait_until(t + 5);  check("basic_pre",   {31'b0, trig}, 32'd0);
      wait_until(t + 6);  check("basic_rise",  {31'b0, trig}, 32'd1);
      wait_until(t + 8);  check("basic_hold",  {31'b0, trig}, 32'd1);
      wait_until(t + 9);  check("basic_fall",  {31'b0, trig}, 32'd0);
      wait_until(t + 16); check("basic_p2",    {31'b0, trig}, 32'd1);
      wait_until(t + 36); check("basic_p4",    {31'b0, trig}, 32'd1);
      wait_until(t + 45); check("basic_busy",  {31'b0, busy}, 32'd1);
      wait_until(t + 46); check("basic_done",  {31'b0, done}, 32'd1);
      check("basic_idle", {31'b0, busy}, 32'd0);
`ifdef ASG_TRIG_SCHED_CNT_EN
      check("basic_cnt", cnt, 32'd4);
`endif
      wait_until(t + 47); check("basic_done1", {31'b0, done}, 32'd0);
      @(negedge dac_clk);

      // Clamping
      do_start(0, 0, 0, 3, 1'b0, t);
      wait_until(t + 1); check("clamp_p1", {31'b0, trig}, 32'd1);
      wait_until(t + 2); check("clamp_g1", {31'b0, trig}, 32'd0);
      wait_until(t + 3); check("clamp_p2", {31'b0, trig}, 32'd1);
      wait_until(t + 5); check("clamp_p3", {31'b0, trig}, 32'd1);
      wait_until(t + 7); check("clamp_done", {31'b0, done}, 32'd1);
      repeat (2) @(negedge dac_clk);

      // External start, level already high
      ext_trig = 1'b1;
      @(negedge dac_clk);
      do_start(2, 8, 1, 2, 1'b1, t);
      wait_until(t + 6); check("ext_nopulse", {31'b0, trig}, 32'd0);
      check("ext_armed", {31'b0, busy}, 32'd1);
      ext_trig = 1'b0;
      @(negedge dac_clk);
      ext_trig = 1'b1;
      e = cyc + 1;
      wait_until(e + 2);  check("ext_pre",  {31'b0, trig}, 32'd0);
      wait_until(e + 3);  check("ext_p1",   {31'b0, trig}, 32'd1);
      wait_until(e + 11); check("ext_p2",   {31'b0, trig}, 32'd1);
      wait_until(e + 19); check("ext_done", {31'b0, done}, 32'd1);
      ext_trig = 1'b0;
      repeat (2) @(negedge dac_clk);

      // Start while busy is ignored
      do_start(1, 6, 2, 3, 1'b0, t);
      wait_until(t + 3);
      delay_v = 0; per_v = 3; wid_v = 1; num_v = 1; use_ext = 1'b0; start = 1'b1;
      @(negedge dac_clk);
      start = 1'b0;
      wait_until(t + 8);  check("busy_p2",   {31'b0, trig}, 32'd1);
      wait_until(t + 14); check("busy_p3",   {31'b0, trig}, 32'd1);
      wait_until(t + 20); check("busy_done", {31'b0, done}, 32'd1);
      repeat (2) @(negedge dac_clk);

      // Abort during the 2nd pulse
      do_start(0, 20, 3, 0, 1'b0, t);
      wait_until(t + 21);
      stop = 1'b1;
      @(negedge dac_clk);
      stop = 1'b0;
      check("abort_trig", {31'b0, trig}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
`ifdef ASG_TRIG_SCHED_CNT_EN
      check("abort_cnt", cnt, 32'd1);
`endif
      repeat (3) @(negedge dac_clk);

      // Start and stop together in IDLE
      delay_v = 0; per_v = 4; wid_v = 1; num_v = 2; use_ext = 1'b0;
      start = 1'b1; stop = 1'b1;
      @(negedge dac_clk);
      start = 1'b0; stop = 1'b0;
      @(negedge dac_clk);
      check("collide_busy", {31'b0, busy}, 32'd0);
      @(negedge dac_clk);

      // Reset mid-train
      do_start(0, 10, 2, 0, 1'b0, t);
      wait_until(t + 24);
      dac_rstn = 1'b0;
      @(negedge dac_clk);
      dac_rstn = 1'b1;
      check("rst_trig", {31'b0, trig}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_cnt",  cnt, 32'd0);
      do_start(1, 4, 1, 2, 1'b0, t);
      wait_until(t + 2);  check("rst_new_p1",   {31'b0, trig}, 32'd1);
      wait_until(t + 10); check("rst_new_done", {31'b0, done}, 32'd1);
      @(negedge dac_clk);

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 5000; i++) begin
         start   = ($urandom_range(0, 9) == 0);
         stop    = ($urandom_range(0, 99) == 0);
         use_ext = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) ext_trig = ~ext_trig;
         dac_rstn = ($urandom_range(0, 999) != 0);
         delay_v = $urandom_range(0, 4);
         per_v   = $urandom_range(0, 9);
         wid_v   = $urandom_range(0, 4);
         num_v   = $urandom_range(0, 4);
         @(negedge dac_clk);
      end
      start = 1'b0; stop = 1'b0; dac_rstn = 1'b1;
      repeat (4) @(negedge dac_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
`default_nettype wire
